ws2812_strip_driver: RTL

- Parametrised successor to the single-pixel LED driver. Holds an internal frame buffer of NUM_LEDS 24-bit pixels, written over a simple write port.
- On start, serialises the whole buffer as one continuous WS2812 bit stream on dout, then holds the latch/reset period.
- Optional continuous-refresh mode re-sends frames back to back. Sits between the pixel-generation logic in top and the LED strip data pin.

---
 rtl/ws2812_strip_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: holds a frame buffer of NUM_LEDS 24-bit pixels and
// serialises it as one continuous WS2812 bit stream followed by a latch gap.
//
// Handshake: start is a level sampled only in IDLE. busy rises on the first
// cycle after start is accepted and falls one cycle after the done pulse,
// unless continuous mode chains straight into the next frame. done is a
// single-cycle pulse that coincides with the LOAD cycle of a chained frame.
module ws2812_strip_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int T_BIT        = 60,
  parameter int T0H          = 17,
  parameter int T1H          = 34,
  parameter int RESET_CYCLES = 2880,
  parameter int COLOR_ORDER  = 0,
  parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  // One timing counter serves both bit timing and the latch gap.
  localparam int TMAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]     BIT_LAST   = TW'(T_BIT - 1);
  localparam logic [TW-1:0]     LATCH_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]     T0H_W      = TW'(T0H);
  localparam logic [TW-1:0]     T1H_W      = TW'(T1H);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   PIX_COUNT  = (ADDR_W + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [23:0]       shift_q, shift_d;
  logic              dout_d, busy_d, done_d;
  logic [TW-1:0]     hi_len;
  logic [ADDR_W-1:0] pix_inc;

  logic [23:0] frame_buf [NUM_LEDS];

  // Buffer stores {R,G,B}; the wire order is applied when a pixel is copied.
  function automatic logic [23:0] reorder(input logic [23:0] px);
    if (COLOR_ORDER == 0) begin
      return {px[15:8], px[23:16], px[7:0]};
    end
    return px;
  endfunction

  // Pixel write port; out-of-range addresses are dropped, buffer has no reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < PIX_COUNT)) begin
      frame_buf[wr_addr] <= wr_data;
    end
  end

  // Next-state logic. dout_d is the line level for the coming cycle, so the
  // registered dout lines up exactly with the bit cell being timed.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    shift_d = shift_q;
    dout_d  = 1'b0;
    done_d  = 1'b0;
    hi_len  = shift_q[23] ? T1H_W : T0H_W;
    pix_inc = pix_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        shift_d = reorder(frame_buf[0]);
        pix_d   = '0;
        bit_d   = '0;
        tcnt_d  = '0;
        dout_d  = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        if (tcnt_q == BIT_LAST) begin
          tcnt_d = '0;
          if (bit_q == 5'd23) begin
            if (pix_q == PIX_LAST) begin
              state_d = LATCH;
            end else begin
              // Next pixel is copied here so there is no gap between pixels.
              pix_d   = pix_inc;
              shift_d = reorder(frame_buf[pix_inc]);
              bit_d   = '0;
              dout_d  = 1'b1;
            end
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            dout_d  = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          dout_d = ((tcnt_q + TW'(1)) < hi_len);
        end
      end

      LATCH: begin
        if (tcnt_q == LATCH_LAST) begin
          tcnt_d  = '0;
          done_d  = 1'b1;
          state_d = continuous ? LOAD : IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // busy covers the whole frame including the done cycle itself.
    busy_d = (state_d != IDLE) || done_d;
  end

  // State, counters and registered outputs; reset forces the line low at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      shift_q <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      shift_q <= shift_d;
      dout    <= dout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
